seg_scan_capture: RTL and testbench

- Receive-side counterpart of the team's 7-segment decoder path: observes a multiplexed, active-low 7-segment display bus (segments plus digit selects) and reconstructs the displayed 5-bit codes, {dp, hex}, for every digit.
- Used for self-check and loopback of the display subsystem, and for bench observation of board displays.
- Filters each sample for stability, encodes the segment pattern back to a code, accumulates a full frame and delivers it with a valid/ready handshake.

---
 rtl/seg_scan_capture.sv | 188 ++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// Observes an active-low multiplexed 7-segment bus and rebuilds the displayed {dp, hex} frame.
// Optional build macro SEG_SCAN_CAPTURE_CHANGE_ONLY_EN: suppress frames identical to the last delivered one.
module seg_scan_capture #(
  parameter int NUM_DIGITS = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              i_seg_n,
  input  logic [NUM_DIGITS-1:0]   i_dig_sel_n,
  output logic [5*NUM_DIGITS-1:0] o_code,
  output logic [NUM_DIGITS-1:0]   o_err_mask,
  output logic                    o_frame_valid,
  input  logic                    i_frame_ready,
  output logic                    o_overrun
);

  localparam int CNT_W = $clog2(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYC - 2);

  typedef enum logic {S_COLLECT = 1'b0, S_HOLD = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              seg_q, seg_d, seg_prev_q, seg_prev_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d, sel_prev_q, sel_prev_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [5*NUM_DIGITS-1:0] shadow_code_q, shadow_code_d, code_q, code_d;
  logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d, err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    valid_q, valid_d, overrun_q, overrun_d;
  logic                    commit, sel_onehot, same_smp, seen_full, handshake, frame_same;
  logic [6:0]              pat;
  logic [3:0]              enc_hex;
  logic                    enc_dp, enc_err;
`ifdef SEG_SCAN_CAPTURE_CHANGE_ONLY_EN
  logic [6*NUM_DIGITS-1:0] last_q, last_d;
`endif

  // Input registers, previous-sample copy and stability counter.
  always_comb begin
    seg_d      = i_seg_n;
    sel_d      = i_dig_sel_n;
    seg_prev_d = seg_q;
    sel_prev_d = sel_q;
    sel_onehot = $onehot(~sel_q);
    same_smp   = (seg_q == seg_prev_q) && (sel_q == sel_prev_q);
    commit     = 1'b0;
    cnt_d      = '0;
    if (sel_onehot && same_smp) begin
      cnt_d  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
      commit = (cnt_q == CNT_PRE);
    end
  end

  always_comb begin
    pat     = ~seg_q[6:0];
    enc_dp  = ~seg_q[7];
    enc_hex = 4'h0;
    enc_err = 1'b0;
    case (pat)
      7'h3f: enc_hex = 4'h0;
      7'h06: enc_hex = 4'h1;
      7'h5b: enc_hex = 4'h2;
      7'h4f: enc_hex = 4'h3;
      7'h66: enc_hex = 4'h4;
      7'h6d: enc_hex = 4'h5;
      7'h7d: enc_hex = 4'h6;
      7'h07: enc_hex = 4'h7;
      7'h7f: enc_hex = 4'h8;
      7'h6f: enc_hex = 4'h9;
      7'h77: enc_hex = 4'ha;
      7'h7c: enc_hex = 4'hb;
      7'h39: enc_hex = 4'hc;
      7'h5e: enc_hex = 4'hd;
      7'h79: enc_hex = 4'he;
      7'h71: enc_hex = 4'hf;
      default: enc_err = 1'b1;
    endcase
  end

  // Output handshake: a frame transfers on any cycle with o_frame_valid & i_frame_ready;
  // while valid is high and ready low, o_code/o_err_mask are held unchanged.
  always_comb begin
    state_d       = state_q;
    shadow_code_d = shadow_code_q;
    shadow_err_d  = shadow_err_q;
    seen_d        = seen_q;
    code_d        = code_q;
    err_d         = err_q;
    valid_d       = valid_q;
    overrun_d     = overrun_q;
    handshake     = valid_q & i_frame_ready;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (commit && !sel_q[k]) begin
        shadow_code_d[5*k +: 5] = {enc_dp, enc_hex};
        shadow_err_d[k]         = enc_err;
        seen_d[k]               = 1'b1;
      end
    end
    seen_full = &seen_d;
`ifdef SEG_SCAN_CAPTURE_CHANGE_ONLY_EN
    last_d = last_q;
    if (handshake) last_d = {code_q, err_q};
    frame_same = ({shadow_code_d, shadow_err_d} == last_d);
`else
    frame_same = 1'b0;
`endif
    if (handshake) valid_d = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (seen_full) begin
          seen_d = '0;
          if (!frame_same) begin
            if (!valid_q || handshake) begin
              code_d  = shadow_code_d;
              err_d   = shadow_err_d;
              valid_d = 1'b1;
            end else begin
              // Pending frame now lives in the shadow; seen restarts to detect a second one.
              state_d = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (i_frame_ready) begin
          state_d = S_COLLECT;
          seen_d  = '0;
          if (!frame_same) begin
            code_d  = shadow_code_d;
            err_d   = shadow_err_d;
            valid_d = 1'b1;
          end
        end else if (seen_full) begin
          seen_d = '0;
          if (!frame_same) overrun_d = 1'b1;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_COLLECT;
      seg_q         <= '1;
      sel_q         <= '1;
      seg_prev_q    <= '1;
      sel_prev_q    <= '1;
      cnt_q         <= '0;
      shadow_code_q <= '0;
      shadow_err_q  <= '0;
      seen_q        <= '0;
      code_q        <= '0;
      err_q         <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      seg_q         <= seg_d;
      sel_q         <= sel_d;
      seg_prev_q    <= seg_prev_d;
      sel_prev_q    <= sel_prev_d;
      cnt_q         <= cnt_d;
      shadow_code_q <= shadow_code_d;
      shadow_err_q  <= shadow_err_d;
      seen_q        <= seen_d;
      code_q        <= code_d;
      err_q         <= err_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
    end
  end

`ifdef SEG_SCAN_CAPTURE_CHANGE_ONLY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= '0;
    else        last_q <= last_d;
  end
`endif

  assign o_code        = code_q;
  assign o_err_mask    = err_q;
  assign o_frame_valid = valid_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: glyph table frames, stability rejects, overrun, reset, change-only.
module tb_seg_scan_capture;
  localparam int ND = 8;
  localparam int FW = 6 * ND;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    i_seg_n;
  logic [ND-1:0] i_dig_sel_n;
  logic [5*ND-1:0] o_code;
  logic [ND-1:0] o_err_mask;
  logic          o_frame_valid;
  logic          i_frame_ready;
  logic          o_overrun;

  seg_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_seg_n(i_seg_n), .i_dig_sel_n(i_dig_sel_n),
    .o_code(o_code), .o_err_mask(o_err_mask), .o_frame_valid(o_frame_valid),
    .i_frame_ready(i_frame_ready), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] seg_n; logic [4:0] code; logic err; } vec_t;
  vec_t tbl[24];

  int n_checks = 0;
  int n_err    = 0;
  logic [FW-1:0] exp_q[$];
  logic          prev_hold = 1'b0;
  logic [FW-1:0] prev_out  = '0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 2 ns after the rising edge; outputs are observed at the falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic show(input int dig, input logic [7:0] seg, input logic [ND-1:0] sel_n, input int n);
    i_seg_n     = seg;
    i_dig_sel_n = sel_n;
    cyc(n);
  endtask

  function automatic logic [ND-1:0] sel_of(input int dig);
    logic [ND-1:0] s;
    s      = '1;
    s[dig] = 1'b0;
    return s;
  endfunction

  task automatic show_rows(input int base, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) show(k, tbl[base + k].seg_n, sel_of(k), 6);
  endtask

  function automatic logic [FW-1:0] frame_exp(input int base);
    logic [5*ND-1:0] c;
    logic [ND-1:0]   e;
    for (int k = 0; k < ND; k++) begin
      c[5*k +: 5] = tbl[base + k].code;
      e[k]        = tbl[base + k].err;
    end
    return {c, e};
  endfunction

  // Scoreboard: every handshake must match the oldest expected frame; held outputs must not move.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (prev_hold && o_frame_valid) check("hold_stable", {o_code, o_err_mask}, prev_out);
      if (o_frame_valid && i_frame_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_frame: got %h expected none", {o_code, o_err_mask});
        end else begin
          check("frame", {o_code, o_err_mask}, exp_q.pop_front());
        end
      end
    end
    prev_hold = (rst_n === 1'b1) && o_frame_valid && !i_frame_ready;
    prev_out  = {o_code, o_err_mask};
  end

  initial begin
    logic [FW-1:0] f;
    tbl[0]  = '{8'hc0, 5'h00, 1'b0};
    tbl[1]  = '{8'hf9, 5'h01, 1'b0};
    tbl[2]  = '{8'ha4, 5'h02, 1'b0};
    tbl[3]  = '{8'hb0, 5'h03, 1'b0};
    tbl[4]  = '{8'h99, 5'h04, 1'b0};
    tbl[5]  = '{8'h92, 5'h05, 1'b0};
    tbl[6]  = '{8'h82, 5'h06, 1'b0};
    tbl[7]  = '{8'hf8, 5'h07, 1'b0};
    tbl[8]  = '{8'h80, 5'h08, 1'b0};
    tbl[9]  = '{8'h90, 5'h09, 1'b0};
    tbl[10] = '{8'h88, 5'h0a, 1'b0};
    tbl[11] = '{8'h83, 5'h0b, 1'b0};
    tbl[12] = '{8'hc6, 5'h0c, 1'b0};
    tbl[13] = '{8'ha1, 5'h0d, 1'b0};
    tbl[14] = '{8'h86, 5'h0e, 1'b0};
    tbl[15] = '{8'h8e, 5'h0f, 1'b0};
    tbl[16] = '{8'h40, 5'h10, 1'b0};  // "0." dp on
    tbl[17] = '{8'hfe, 5'h00, 1'b1};  // partial glyph
    tbl[18] = '{8'h7f, 5'h10, 1'b1};  // dp only, segments blank
    tbl[19] = '{8'h00, 5'h18, 1'b0};  // "8."
    tbl[20] = '{8'h08, 5'h1a, 1'b0};  // "A."
    tbl[21] = '{8'hff, 5'h00, 1'b1};  // blank
    tbl[22] = '{8'h7e, 5'h10, 1'b1};  // partial with dp
    tbl[23] = '{8'h06, 5'h1e, 1'b0};  // "E."

    rst_n = 1'b0; i_frame_ready = 1'b0; i_seg_n = '1; i_dig_sel_n = '1;
    cyc(3);
    check("rst_code",    FW'(o_code), '0);
    check("rst_err",     FW'(o_err_mask), '0);
    check("rst_valid",   FW'(o_frame_valid), '0);
    check("rst_overrun", FW'(o_overrun), '0);
    rst_n = 1'b1; i_frame_ready = 1'b1;
    cyc(1);

    // Three frames from the glyph table, ready held high.
    for (int i = 0; i < 24; i++) begin
      if (i % 8 == 0) exp_q.push_back(frame_exp(i - (i % 8)));
      show(i % 8, tbl[i].seg_n, sel_of(i % 8), 6);
    end
    cyc(2);
    check("table_frames_done", FW'(exp_q.size()), '0);

    // Too-short hold and a two-hot select must not commit digit 0.
    show(0, tbl[9].seg_n, sel_of(0), 3);
    show(0, tbl[9].seg_n, 8'b1111_1100, 6);
    show_rows(0, 1, 7);
    check("no_commit_valid", FW'(o_frame_valid), '0);
    f = frame_exp(0);
    f[ND +: 5] = tbl[9].code;
    f[0]       = tbl[9].err;
    exp_q.push_back(f);
    show(0, tbl[9].seg_n, sel_of(0), 6);
    cyc(1);
    check("no_commit_frame_done", FW'(exp_q.size()), '0);

    // Ready low over three scans: A held, B pending, C overruns and replaces B.
    i_frame_ready = 1'b0;
    show_rows(0, 0, 7);
    check("hold_a_valid", FW'(o_frame_valid), FW'(1));
    check("hold_a_code",  {o_code, o_err_mask}, frame_exp(0));
    show_rows(8, 0, 7);
    check("no_overrun_yet", FW'(o_overrun), '0);
    show_rows(16, 0, 7);
    check("ovr_valid", FW'(o_frame_valid), FW'(1));
    check("ovr_code",  {o_code, o_err_mask}, frame_exp(0));
    check("ovr_flag",  FW'(o_overrun), FW'(1));
    exp_q.push_back(frame_exp(0));
    exp_q.push_back(frame_exp(16));
    i_frame_ready = 1'b1;
    cyc(4);
    check("ovr_delivered", FW'(exp_q.size()), '0);
    check("ovr_valid_drop", FW'(o_frame_valid), '0);
    check("ovr_sticky", FW'(o_overrun), FW'(1));

    // Reset in the middle of a frame.
    i_frame_ready = 1'b0;
    show_rows(0, 0, 4);
    rst_n = 1'b0;
    cyc(1);
    check("mid_rst_code",    FW'(o_code), '0);
    check("mid_rst_err",     FW'(o_err_mask), '0);
    check("mid_rst_valid",   FW'(o_frame_valid), '0);
    check("mid_rst_overrun", FW'(o_overrun), '0);
    rst_n = 1'b1;
    show_rows(0, 5, 7);
    check("post_rst_partial", FW'(o_frame_valid), '0);
    show_rows(0, 0, 7);
    check("post_rst_valid", FW'(o_frame_valid), FW'(1));
    exp_q.push_back(frame_exp(0));
    i_frame_ready = 1'b1;
    cyc(3);

    // Identical scan again: suppressed only in the change-only build.
`ifndef SEG_SCAN_CAPTURE_CHANGE_ONLY_EN
    exp_q.push_back(frame_exp(0));
`endif
    show_rows(0, 0, 7);
    cyc(3);
    check("final_queue_empty", FW'(exp_q.size()), '0);
    check("final_valid", FW'(o_frame_valid), '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
